// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the instruction decoder.
// Holds the md_op encoding, the default operation latencies and the FSM
// state type, plus a helper that tells whether an opcode occupies the unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the operations that keep the unit busy for several cycles.
  function automatic logic is_md_launch(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed combinationally at launch, parked in temp_hi/temp_lo,
// and committed to HI/LO after a counted latency so the pipeline sees the
// same stall timing as an iterative implementation.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-low
//   start     one-cycle launch pulse for md_op
//   md_op     operation code (mdu_pkg::md_op_e encoding)
//   md_we     write strobe for MTHI/MTLO
//   rs_data   first operand / MTHI-MTLO source
//   rt_data   second operand
//   busy      high while a multiply/divide is in flight
//   hi, lo    architectural HI/LO registers
//   md_rdata  HI for MFHI, LO for MFLO, else zero (combinational)
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic        md_we,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  md_op_e      op;
  mdu_state_e  state;
  logic [5:0]  count;
  logic [31:0] temp_hi;
  logic [31:0] temp_lo;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [63:0] prod;
  logic [31:0] div_safe;
  logic signed [31:0] squot;
  logic signed [31:0] srem;
  logic        launch;

  assign op     = md_op_e'(md_op);
  assign launch = start && is_md_launch(op);
  assign busy   = (state == ST_RUN);

  // Divisor forced non-zero so the dividers never see zero; a real divide by
  // zero is handled by latching the current HI/LO as the "result", which
  // leaves them unchanged at commit (HI/LO cannot change during RUN).
  assign div_safe = (rt_data == '0) ? 32'd1 : rt_data;
  assign squot    = $signed(rs_data) / $signed(div_safe);
  assign srem     = $signed(rs_data) % $signed(div_safe);

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    prod   = '0;
    case (op)
      MD_MULT: begin
        // Low 64 bits of the product of sign-extended operands equal the
        // signed 32x32 product.
        prod   = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'd0, rs_data} * {32'd0, rt_data};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV: begin
        if (rt_data != '0) begin
          if (rs_data == 32'h8000_0000 && rt_data == '1) begin
            res_lo = 32'h8000_0000;
            res_hi = '0;
          end else begin
            res_lo = squot;
            res_hi = srem;
          end
        end
      end
      MD_DIVU: begin
        if (rt_data != '0) begin
          res_lo = rs_data / div_safe;
          res_hi = rs_data % div_safe;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state   <= ST_RUN;
            count   <= (op == MD_MULT || op == MD_MULTU) ? 6'(MULT_CYCLES) : 6'(DIV_CYCLES);
            temp_hi <= res_hi;
            temp_lo <= res_lo;
          end else if (md_we && op == MD_MTHI) begin
            hi <= rs_data;
          end else if (md_we && op == MD_MTLO) begin
            lo <= rs_data;
          end
        end
        ST_RUN: begin
          if (count <= 6'd1) begin
            state <= ST_IDLE;
            count <= '0;
            hi    <= temp_hi;
            lo    <= temp_lo;
          end else begin
            count <= count - 6'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    md_rdata = '0;
    if (op == MD_MFHI) md_rdata = hi;
    else if (op == MD_MFLO) md_rdata = lo;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: a timestamp-based reference model plus
// directed scenarios with hand-computed expectations.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  typedef longint unsigned u64_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic        md_we = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .md_we(md_we),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo),
    .md_rdata(md_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: an operation launched at edge E commits at edge E+N.
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  bit          p_write = 1'b0;
  bit          m_active = 1'b0;
  int          m_end = 0;

  always @(posedge clk) begin
    longint sa, sb, sq, sr;
    u64_t   ua, ub, uq;
    cyc++;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_active = 1'b0;
    end else if (m_active) begin
      if (cyc == m_end) begin
        m_active = 1'b0;
        if (p_write) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (start && (md_op == MD_MULT || md_op == MD_MULTU ||
                           md_op == MD_DIV  || md_op == MD_DIVU)) begin
      sa = longint'($signed(rs_data)); sb = longint'($signed(rt_data));
      ua = u64_t'(rs_data);            ub = u64_t'(rt_data);
      p_write  = 1'b1;
      m_active = 1'b1;
      if (md_op == MD_MULT) begin
        sq = sa * sb; p_hi = sq[63:32]; p_lo = sq[31:0]; m_end = cyc + MC;
      end else if (md_op == MD_MULTU) begin
        uq = ua * ub; p_hi = uq[63:32]; p_lo = uq[31:0]; m_end = cyc + MC;
      end else begin
        m_end   = cyc + DC;
        p_write = (rt_data != 0);
        if (p_write && md_op == MD_DIV) begin
          sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0];
        end else if (p_write) begin
          uq = ua / ub; p_lo = uq[31:0]; uq = ua % ub; p_hi = uq[31:0];
        end
      end
    end else if (md_we && md_op == MD_MTHI) begin
      m_hi = rs_data;
    end else if (md_we && md_op == MD_MTLO) begin
      m_lo = rs_data;
    end
  end

  // Per-cycle comparison against the model, just after each edge.
  always @(posedge clk) begin
    logic [31:0] exp_rd;
    #1;
    exp_rd = (md_op == MD_MFHI) ? m_hi : (md_op == MD_MFLO) ? m_lo : 32'd0;
    chk("cyc_busy", {31'd0, busy}, {31'd0, m_active});
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
    chk("cyc_md_rdata", md_rdata, exp_rd);
  end

  task automatic clear_inputs();
    start = 1'b0; md_we = 1'b0; md_op = MD_NONE; rs_data = '0; rt_data = '0;
  endtask

  // Returns at the negedge of cycle T+1 (launch edge T just passed).
  task automatic launch(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic we);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; md_we = we;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic write_hilo(input md_op_e op, input logic [31:0] v);
    @(negedge clk);
    md_we = 1'b1; md_op = op; rs_data = v;
    @(negedge clk);
    clear_inputs();
  endtask

  // Counts busy cycles from the current negedge on; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle_timeout: busy still high after %0d cycles, expected low", n);
    end
  endtask

  initial begin
    int n;
    clear_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b1;

    // MULT -2 * 3
    launch(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(n);
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);

    // DIVU 100 / 7
    launch(MD_DIVU, 32'd100, 32'd7, 1'b0);
    wait_idle(n);
    chk("divu_busy_cycles", n, 32'd10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("model_divu_hi", m_hi, 32'd2);

    // DIV -7 / 2
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("model_div_lo", m_lo, 32'hFFFF_FFFD);

    // DIV overflow case
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);
    chk("model_divovf_lo", m_lo, 32'h8000_0000);

    // Divide by zero keeps HI/LO
    write_hilo(MD_MTHI, 32'h11);
    write_hilo(MD_MTLO, 32'h22);
    launch(MD_DIV, 32'd55, 32'd0, 1'b0);
    wait_idle(n);
    chk("divzero_busy_cycles", n, 32'd10);
    chk("divzero_hi", hi, 32'h11);
    chk("divzero_lo", lo, 32'h22);

    // Reset mid-operation at T+3
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    chk("multu_busy_cycles", n, 32'd5);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // MTHI during RUN ignored, then in IDLE
    launch(MD_MULT, 32'd3, 32'd4, 1'b0);
    md_we = 1'b1; md_op = MD_MTHI; rs_data = 32'hABCD;
    @(negedge clk);
    clear_inputs();
    wait_idle(n);
    chk("mthi_run_hi", hi, 32'd0);
    chk("mthi_run_lo", lo, 32'd12);
    write_hilo(MD_MTHI, 32'hABCD);
    chk("mthi_idle_hi", hi, 32'hABCD);
    md_op = MD_MFHI;
    #1;
    chk("mfhi_rdata", md_rdata, 32'hABCD);
    md_op = MD_MFLO;
    #1;
    chk("mflo_rdata", md_rdata, 32'd12);
    md_op = MD_NONE;

    // Second start during RUN ignored
    launch(MD_DIVU, 32'd50, 32'd5, 1'b0);
    @(negedge clk);
    start = 1'b1; md_op = MD_MULTU; rs_data = 32'd7; rt_data = 32'd7;
    @(negedge clk);
    clear_inputs();
    wait_idle(n);
    chk("restart_busy_cycles", n, 32'd8);
    chk("restart_lo", lo, 32'd10);
    chk("restart_hi", hi, 32'd0);

    // start and md_we together: the launch wins
    launch(MD_MULT, 32'd2, 32'd5, 1'b1);
    wait_idle(n);
    chk("startwe_busy_cycles", n, 32'd5);
    chk("startwe_lo", lo, 32'd10);
    chk("startwe_hi", hi, 32'd0);

    // start with a non-launch op does not enter RUN
    @(negedge clk);
    start = 1'b1; md_op = MD_MFHI;
    @(negedge clk);
    clear_inputs();
    chk("mfhi_start_busy", {31'd0, busy}, 32'd0);

    // reset beats start in the same cycle
    @(negedge clk);
    reset = 1'b0; start = 1'b1; md_op = MD_MULT; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    chk("resetprio_busy", {31'd0, busy}, 32'd0);
    chk("resetprio_lo", lo, 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-low (reset==0 clears state at the rising edge).
REQ-005 start  input  1  one-cycle pulse from E stage launching the operation on md_op.
REQ-006 md_op  input  4  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 md_we  input  1  write strobe for MTHI/MTLO.
REQ-008 rs_data  input  32  first operand / mthi-mtlo source.
REQ-009 rt_data  input  32  second operand.
REQ-010 busy  output  1  registered; high while an operation is in flight, feeds the pipeline stall with start.
REQ-011 hi  output  32  architectural HI register.
REQ-012 lo  output  32  architectural LO register.
REQ-013 md_rdata  output  32  combinational: hi when md_op==MFHI, lo when md_op==MFLO, else 0.

Function
REQ-014 Two states: IDLE and RUN; busy SHALL be 1 exactly when state==RUN.
REQ-015 IDLE->RUN at edge T when start==1 and md_op is MULT/MULTU/DIV/DIVU; 6-bit counter loaded with MULT_CYCLES or DIV_CYCLES.
REQ-016 At edge T operands' results SHALL be computed and held in internal temp_hi/temp_lo; hi/lo unchanged during RUN.
REQ-017 busy SHALL be 1 for cycles T+1 .. T+N (N = selected latency); counter decrements each RUN cycle.
REQ-018 On the edge ending cycle T+N: RUN->IDLE, hi<=temp_hi, lo<=temp_lo; new values visible in cycle T+N+1 with busy==0.
REQ-019 MULT: signed 32x32->64, hi=[63:32], lo=[31:0]; MULTU: unsigned.
REQ-020 DIV: lo=signed quotient truncated toward zero, hi=remainder with dividend's sign; DIVU unsigned.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-022 Divide by zero (rt_data==0): full DIV_CYCLES busy, hi/lo SHALL keep prior values.
REQ-023 start while RUN SHALL be ignored (no restart, no counter reload).
REQ-024 md_we with MTHI/MTLO in IDLE SHALL write rs_data to hi/lo at that edge; ignored during RUN.
REQ-025 start with MTHI/MTLO/MFHI/MFLO/NONE SHALL NOT enter RUN.
REQ-026 start and md_we same cycle: multiply/divide start wins, write ignored.

Reset
REQ-027 reset==0 at an edge SHALL force state=IDLE, counter=0, busy=0, hi=0, lo=0, temp_hi=temp_lo=0, including mid-operation (result discarded).
REQ-028 reset SHALL take priority over start and md_we in the same cycle.

Structure
REQ-029 md_op encodings and default latencies SHALL live in shared package mdu_pkg, also used by the decoder.
REQ-030 No sub-module; datapath uses combinational */÷ with latency modelled by the counter.

Verification
REQ-031 MULT rs=0xFFFFFFFE(-2), rt=3 start at T -> busy T+1..T+5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+6.
REQ-032 DIVU rs=100, rt=7 -> busy 10 cycles, then lo=14, hi=2; DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIV rt=0 after hi=0x11, lo=0x22 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
REQ-034 MULTU start, reset==0 at T+3 -> busy=0, hi=lo=0 next cycle; later start works normally.
REQ-035 MTHI rs=0xABCD during RUN -> ignored; in IDLE -> hi=0xABCD next cycle, md_rdata=0xABCD with md_op=MFHI.
REQ-036 Second start during RUN at T+2 -> busy still drops after T+N of first op, result of first op only.
